// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard scoreboard.
//   xflush_state_e : exception-flush hold FSM states (RUN, XPEND)
//   FWD_NONE       : forward-select code meaning "read from register file"
//   STAGE_W        : stage index of writeback (always the lowest index)
//   stage_e()      : stage index of execute for a given stage count
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    XPEND = 1'b1
  } xflush_state_e;

  localparam int unsigned FWD_NONE = 32'd0;
  localparam int unsigned STAGE_W  = 32'd0;

  // Execute is the youngest post-decode stage, i.e. the highest index.
  function automatic int unsigned stage_e(input int unsigned num_stages);
    return num_stages - 32'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: pipeline <-> hazard unit signal bundle.
//   master modport : pipeline side, drives stall requests, redirects,
//                    decode read addresses, per-stage writer info and
//                    long-op events; receives forwarding/stall/flush.
//   slave modport  : hazard unit side (opposite directions).
//   perf_lu_cnt / perf_mem_cnt are only live when the hazard unit is
//   built with HAZARD_PERF_EN; otherwise they read 0.
interface hazard_scoreboard_if #(
  parameter int NUM_STAGES   = 4,
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_AW       = 5,
  parameter int FWD_W        = $clog2(NUM_STAGES + 1)
);

  logic                           i_cache_stall;
  logic                           d_cache_stall;
  logic                           alu_stallE;
  logic                           flush_exceptionM;
  logic                           flush_pred_failedE;
  logic                           jumpD;
  logic                           pred_takeD;
  logic [NUM_RD_PORTS*REG_AW-1:0] rd_addrD;
  logic [NUM_STAGES-1:0]          wr_en;
  logic [NUM_STAGES*REG_AW-1:0]   wr_addr;
  logic [NUM_STAGES-1:0]          late;
  logic                           lop_issueE;
  logic [REG_AW-1:0]              lop_addrE;
  logic                           lop_done;
  logic [REG_AW-1:0]              lop_done_addr;
  logic                           lop_kill;

  logic [NUM_RD_PORTS*FWD_W-1:0]  forward_sel;
  logic                           stallF;
  logic                           stallF2;
  logic                           stallD;
  logic [NUM_STAGES-1:0]          stall_bk;
  logic [NUM_STAGES-1:0]          flush_bk;
  logic                           flushF2;
  logic                           flushD;
  logic                           stallDblank;
  logic                           longest_stall;
  logic [31:0]                    perf_lu_cnt;
  logic [31:0]                    perf_mem_cnt;

  modport master (
    output i_cache_stall, d_cache_stall, alu_stallE, flush_exceptionM,
           flush_pred_failedE, jumpD, pred_takeD, rd_addrD, wr_en, wr_addr,
           late, lop_issueE, lop_addrE, lop_done, lop_done_addr, lop_kill,
    input  forward_sel, stallF, stallF2, stallD, stall_bk, flush_bk,
           flushF2, flushD, stallDblank, longest_stall, perf_lu_cnt,
           perf_mem_cnt
  );

  modport slave (
    input  i_cache_stall, d_cache_stall, alu_stallE, flush_exceptionM,
           flush_pred_failedE, jumpD, pred_takeD, rd_addrD, wr_en, wr_addr,
           late, lop_issueE, lop_addrE, lop_done, lop_done_addr, lop_kill,
    output forward_sel, stallF, stallF2, stallD, stall_bk, flush_bk,
           flushF2, flushD, stallDblank, longest_stall, perf_lu_cnt,
           perf_mem_cnt
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forwarding source select for one decode read port.
//   rd_addr  in  : source register of this port
//   wr_en    in  : per-stage write enable (index 0 = W ... top = E)
//   wr_addr  in  : per-stage destination registers, packed
//   late     in  : per-stage "result not ready yet"
//   fwd_sel  out : 0 = no forward, k = forward from stage k-1
//   load_use out : selected source is not ready, decode must wait
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int REG_AW     = 5,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_AW-1:0]            rd_addr,
  input  logic [NUM_STAGES-1:0]        wr_en,
  input  logic [NUM_STAGES*REG_AW-1:0] wr_addr,
  input  logic [NUM_STAGES-1:0]        late,
  output logic [FWD_W-1:0]             fwd_sel,
  output logic                         load_use
);

  // Priority match: ascending scan so the youngest matching stage wins; r0 never forwards.
  always_comb begin
    fwd_sel  = FWD_W'(FWD_NONE);
    load_use = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      if ((rd_addr != {REG_AW{1'b0}}) && wr_en[k-1] &&
          (wr_addr[(k-1)*REG_AW +: REG_AW] == rd_addr)) begin
        fwd_sel  = FWD_W'(k);
        load_use = late[k-1];
      end else begin
        fwd_sel  = fwd_sel;
        load_use = load_use;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-side hazard unit for the in-order pipeline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hazard_scoreboard_if.slave -- stall requests, redirects,
//              decode reads, per-stage writers, long-op events in;
//              forward selects, per-stage stall/flush, perf counters out.
// State: long-op busy bit per register, plus a RUN/XPEND FSM that keeps
// an exception flush asserted until a concurrent cache stall clears.
// Build option HAZARD_PERF_EN adds the load-use and cache-stall cycle
// counters; without it the counter outputs are tied to 0.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int NUM_RD_PORTS = 2,
  parameter int REG_AW       = 5,
  parameter int FWD_W        = $clog2(NUM_STAGES + 1)
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);

  localparam int E    = int'(stage_e(NUM_STAGES));
  localparam int NREG = 2 ** REG_AW;
  localparam logic [NREG-1:0] BIT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [FWD_W-1:0]        fwd_sel   [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] lu_port;
  logic [NREG-1:0]         busy_q, busy_d;
  xflush_state_e           state_q, state_d;
  logic                    cache_miss, cstall, sb_stall, stall_dblank;
  logic                    xflush, stall_d, lop_set;
  logic [NUM_STAGES-1:0]   stall_bk, flush_bk;
  logic [NREG-1:0]         set_mask, clr_mask;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    hazard_fwd_sel #(
      .NUM_STAGES (NUM_STAGES),
      .REG_AW     (REG_AW),
      .FWD_W      (FWD_W)
    ) u_fwd_sel (
      .rd_addr  (bus.rd_addrD[p*REG_AW +: REG_AW]),
      .wr_en    (bus.wr_en),
      .wr_addr  (bus.wr_addr),
      .late     (bus.late),
      .fwd_sel  (fwd_sel[p]),
      .load_use (lu_port[p])
    );
  end

  // Pack per-port selects onto the bus.
  always_comb begin
    bus.forward_sel = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      bus.forward_sel[p*FWD_W +: FWD_W] = fwd_sel[p];
    end
  end

  // Scoreboard stall: a port waits on an outstanding long op to a non-zero register.
  always_comb begin
    sb_stall = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      sb_stall = sb_stall | ((bus.rd_addrD[p*REG_AW +: REG_AW] != {REG_AW{1'b0}}) &
                             busy_q[bus.rd_addrD[p*REG_AW +: REG_AW]]);
    end
  end

  // Stall and flush network for every pipeline register.
  always_comb begin
    cache_miss   = bus.i_cache_stall | bus.d_cache_stall;
    cstall       = cache_miss | bus.alu_stallE;
    stall_dblank = (|lu_port) | sb_stall;
    xflush       = bus.flush_exceptionM | (state_q == XPEND);
    stall_d      = cstall | stall_dblank;
    stall_bk     = {NUM_STAGES{cstall}};
    flush_bk     = {NUM_STAGES{xflush}};
    // W has already committed; only E also bubbles on a decode-only stall.
    flush_bk[STAGE_W] = 1'b0;
    flush_bk[E]       = xflush | (stall_dblank & ~cstall);
  end

  assign bus.stallDblank   = stall_dblank;
  assign bus.longest_stall = cstall;
  assign bus.stallD        = stall_d;
  assign bus.stallF2       = stall_d;
  assign bus.stallF        = stall_d & ~xflush;
  assign bus.stall_bk      = stall_bk;
  assign bus.flush_bk      = flush_bk;
  assign bus.flushF2       = xflush | bus.flush_pred_failedE |
                             ((bus.jumpD | bus.pred_takeD) & ~stall_d);
  assign bus.flushD        = xflush | (bus.flush_pred_failedE & ~stall_d);

  // Busy-bit next state: set beats clear, kill beats everything, r0 never busy.
  always_comb begin
    lop_set  = bus.lop_issueE & ~stall_bk[E] & ~flush_bk[E];
    set_mask = lop_set      ? (BIT0 << bus.lop_addrE)     : {NREG{1'b0}};
    clr_mask = bus.lop_done ? (BIT0 << bus.lop_done_addr) : {NREG{1'b0}};
    busy_d   = bus.lop_kill ? {NREG{1'b0}} : ((busy_q & ~clr_mask) | set_mask);
    busy_d[0] = 1'b0;
  end

  // Exception-flush hold FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = (bus.flush_exceptionM & cache_miss) ? XPEND : RUN;
      XPEND:   state_d = cache_miss ? XPEND : RUN;
      default: state_d = RUN;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= {NREG{1'b0}};
      state_q <= RUN;
    end else begin
      busy_q  <= busy_d;
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lu_q, perf_lu_d, perf_mem_q, perf_mem_d;

  // Counter increments; both wrap naturally at 2^32.
  always_comb begin
    perf_lu_d  = (stall_dblank & ~cstall) ? (perf_lu_q + 32'd1) : perf_lu_q;
    perf_mem_d = cache_miss ? (perf_mem_q + 32'd1) : perf_mem_q;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q  <= 32'd0;
      perf_mem_q <= 32'd0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_mem_q <= perf_mem_d;
    end
  end

  assign bus.perf_lu_cnt  = perf_lu_q;
  assign bus.perf_mem_cnt = perf_mem_q;
`else
  assign bus.perf_lu_cnt  = 32'd0;
  assign bus.perf_mem_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a
// rule-level model (busy set, pending-flush flag, counters).
module tb_hazard_scoreboard;

  localparam int NS = 4;
  localparam int NP = 2;
  localparam int AW = 5;
  localparam int FW = $clog2(NS + 1);
  localparam int NR = 2 ** AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_STAGES(NS), .NUM_RD_PORTS(NP), .REG_AW(AW)) hif ();

  hazard_scoreboard #(.NUM_STAGES(NS), .NUM_RD_PORTS(NP), .REG_AW(AW), .FWD_W(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  int errors = 0;
  int checks = 0;

  // model state
  bit          m_busy [NR];
  bit          m_xpend;
  logic [31:0] m_lu, m_mem;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected combinational results from the rules, given inputs and model state.
  function automatic void model_eval(output int fs[NP], output bit cst, output bit dbl,
                                     output bit xfl);
    bit lu, sb;
    int a;
    lu = 1'b0; sb = 1'b0;
    for (int p = 0; p < NP; p++) begin
      a = int'(hif.rd_addrD[p*AW +: AW]);
      fs[p] = 0;
      if (a != 0) begin
        for (int k = NS; k >= 1; k--)
          if (fs[p] == 0 && hif.wr_en[k-1] && int'(hif.wr_addr[(k-1)*AW +: AW]) == a) fs[p] = k;
        if (fs[p] != 0 && hif.late[fs[p]-1]) lu = 1'b1;
        if (m_busy[a]) sb = 1'b1;
      end
    end
    cst = hif.i_cache_stall | hif.d_cache_stall | hif.alu_stallE;
    dbl = lu | sb;
    xfl = hif.flush_exceptionM | m_xpend;
  endfunction

  // Model state update on each rising edge.
  always @(posedge clk) begin
    int fs[NP];
    bit cst, dbl, xfl, ok, cm;
    model_eval(fs, cst, dbl, xfl);
    cm = hif.i_cache_stall | hif.d_cache_stall;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_busy[r] <= 1'b0;
      m_xpend <= 1'b0;
      m_lu    <= 32'd0;
      m_mem   <= 32'd0;
    end else begin
      ok = hif.lop_issueE && !cst && !(xfl || (dbl && !cst));
      if (hif.lop_kill) begin
        for (int r = 0; r < NR; r++) m_busy[r] <= 1'b0;
      end else begin
        if (hif.lop_done) m_busy[hif.lop_done_addr] <= 1'b0;
        if (ok) m_busy[hif.lop_addrE] <= 1'b1;
      end
      m_busy[0] <= 1'b0;
      m_xpend <= m_xpend ? cm : (hif.flush_exceptionM && cm);
      if (dbl && !cst) m_lu <= m_lu + 32'd1;
      if (cm) m_mem <= m_mem + 32'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int fs[NP];
    bit cst, dbl, xfl, sd;
    logic [NS-1:0] efb;
    logic [31:0] elu, emem;
    model_eval(fs, cst, dbl, xfl);
    sd = cst | dbl;
    for (int s = 0; s < NS; s++) efb[s] = (s == 0) ? 1'b0 : (s == NS-1) ? (xfl | (dbl & ~cst)) : xfl;
`ifdef HAZARD_PERF_EN
    elu = m_lu; emem = m_mem;
`else
    elu = 32'd0; emem = 32'd0;
`endif
    for (int p = 0; p < NP; p++) chk("m_forward_sel", 64'(hif.forward_sel[p*FW +: FW]), 64'(fs[p]));
    chk("m_stallDblank", 64'(hif.stallDblank), 64'(dbl));
    chk("m_longest",     64'(hif.longest_stall), 64'(cst));
    chk("m_stallD",      64'(hif.stallD), 64'(sd));
    chk("m_stallF2",     64'(hif.stallF2), 64'(sd));
    chk("m_stallF",      64'(hif.stallF), 64'(sd & ~xfl));
    chk("m_stall_bk",    64'(hif.stall_bk), cst ? 64'(4'hF) : 64'd0);
    chk("m_flush_bk",    64'(hif.flush_bk), 64'(efb));
    chk("m_flushF2",     64'(hif.flushF2),
        64'(xfl | hif.flush_pred_failedE | ((hif.jumpD | hif.pred_takeD) & ~sd)));
    chk("m_flushD",      64'(hif.flushD), 64'(xfl | (hif.flush_pred_failedE & ~sd)));
    chk("m_perf_lu",     64'(hif.perf_lu_cnt), 64'(elu));
    chk("m_perf_mem",    64'(hif.perf_mem_cnt), 64'(emem));
  end

  task automatic idle();
    hif.i_cache_stall = 1'b0; hif.d_cache_stall = 1'b0; hif.alu_stallE = 1'b0;
    hif.flush_exceptionM = 1'b0; hif.flush_pred_failedE = 1'b0;
    hif.jumpD = 1'b0; hif.pred_takeD = 1'b0;
    hif.rd_addrD = '0; hif.wr_en = '0; hif.wr_addr = '0; hif.late = '0;
    hif.lop_issueE = 1'b0; hif.lop_addrE = '0;
    hif.lop_done = 1'b0; hif.lop_done_addr = '0; hif.lop_kill = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    tick(); idle(); hif.lop_issueE = 1'b1; hif.lop_addrE = a;
  endtask

  logic [31:0] exp_lu, exp_mem;

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fwd",     64'(hif.forward_sel), 64'd0);
    chk("rst_stallD",  64'(hif.stallD), 64'd0);
    chk("rst_flushD",  64'(hif.flushD), 64'd0);
    chk("rst_flush_bk",64'(hif.flush_bk), 64'd0);
    chk("rst_perf",    64'(hif.perf_lu_cnt | hif.perf_mem_cnt), 64'd0);

    // forwarding priority
    tick(); idle();
    hif.rd_addrD = {5'd0, 5'd5}; hif.wr_en = 4'b1001;
    hif.wr_addr = {5'd5, 5'd0, 5'd0, 5'd5};
    @(negedge clk); chk("fwd_E_wins", 64'(hif.forward_sel[FW-1:0]), 64'd4);
    tick(); hif.wr_en = 4'b0001;
    @(negedge clk); chk("fwd_W_only", 64'(hif.forward_sel[FW-1:0]), 64'd1);

    // load-use on port 1
    tick(); idle();
    hif.late = 4'b1000; hif.wr_en = 4'b1000; hif.wr_addr = {5'd7, 15'd0};
    hif.rd_addrD = {5'd7, 5'd0};
    @(negedge clk);
    chk("lu_dblank",   64'(hif.stallDblank), 64'd1);
    chk("lu_stallD",   64'(hif.stallD), 64'd1);
    chk("lu_flush_bk", 64'(hif.flush_bk), 64'(4'b1000));
    chk("lu_stall_bk", 64'(hif.stall_bk), 64'd0);

    // scoreboard set / clear timing
    issue(5'd9);
    @(negedge clk); chk("sb_issue_cycle", 64'(hif.stallD), 64'd0);
    tick(); idle(); hif.rd_addrD = {5'd0, 5'd9};
    @(negedge clk); chk("sb_busy", 64'(hif.stallD), 64'd1);
    tick(); hif.lop_done = 1'b1; hif.lop_done_addr = 5'd9;
    @(negedge clk); chk("sb_no_bypass", 64'(hif.stallD), 64'd1);
    tick(); hif.lop_done = 1'b0;
    @(negedge clk); chk("sb_cleared", 64'(hif.stallD), 64'd0);
    issue(5'd9);
    issue(5'd9); hif.lop_done = 1'b1; hif.lop_done_addr = 5'd9;
    tick(); idle(); hif.rd_addrD = {5'd9, 5'd0};
    @(negedge clk); chk("sb_set_wins", 64'(hif.stallD), 64'd1);
    tick(); idle(); hif.lop_done = 1'b1; hif.lop_done_addr = 5'd9;
    tick(); idle(); hif.rd_addrD = {5'd9, 5'd0};
    @(negedge clk); chk("sb_clear2", 64'(hif.stallD), 64'd0);

    // exception flush held across a 3-cycle d-cache stall
    for (int i = 0; i < 4; i++) begin
      tick(); idle();
      hif.flush_exceptionM = (i == 0); hif.d_cache_stall = (i < 3);
      @(negedge clk);
      chk("xp_flushD",  64'(hif.flushD), 64'd1);
      chk("xp_flushF2", 64'(hif.flushF2), 64'd1);
      chk("xp_stallF",  64'(hif.stallF), 64'd0);
    end
    tick(); idle();
    @(negedge clk);
    chk("xp_done_flushD",  64'(hif.flushD), 64'd0);
    chk("xp_done_flushF2", 64'(hif.flushF2), 64'd0);

    // kill clears every outstanding long op; r0 never busy
    issue(5'd3); issue(5'd4); issue(5'd6);
    tick(); idle(); hif.lop_kill = 1'b1;
    tick(); idle(); hif.rd_addrD = {5'd4, 5'd3};
    @(negedge clk); chk("kill_r3r4", 64'(hif.stallD), 64'd0);
    tick(); idle(); hif.rd_addrD = {5'd0, 5'd6};
    @(negedge clk); chk("kill_r6", 64'(hif.stallD), 64'd0);
    issue(5'd0);
    tick(); idle(); hif.rd_addrD = {5'd0, 5'd0};
    @(negedge clk); chk("r0_no_stall", 64'(hif.stallD), 64'd0);

    // reset while XPEND drops the pending flush
    tick(); idle(); hif.flush_exceptionM = 1'b1; hif.d_cache_stall = 1'b1;
    tick(); idle(); hif.d_cache_stall = 1'b1; rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk); chk("rst_xpend_flushD", 64'(hif.flushD), 64'd0);

    // performance counters
    tick(); idle(); rst = 1'b1;
    tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); idle();
      hif.late = 4'b1000; hif.wr_en = 4'b1000; hif.wr_addr = {5'd7, 15'd0};
      hif.rd_addrD = {5'd0, 5'd7};
    end
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); hif.i_cache_stall = 1'b1;
    end
    tick(); idle();
`ifdef HAZARD_PERF_EN
    exp_lu = 32'd5; exp_mem = 32'd3;
`else
    exp_lu = 32'd0; exp_mem = 32'd0;
`endif
    @(negedge clk);
    chk("perf_lu",  64'(hif.perf_lu_cnt), 64'(exp_lu));
    chk("perf_mem", 64'(hif.perf_mem_cnt), 64'(exp_mem));
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("perf_rst", 64'(hif.perf_lu_cnt | hif.perf_mem_cnt), 64'd0);

    // randomized traffic, checked by the per-cycle model compare
    for (int n = 0; n < 3000; n++) begin
      tick();
      hif.i_cache_stall      = ($urandom % 10) == 0;
      hif.d_cache_stall      = ($urandom % 8) == 0;
      hif.alu_stallE         = ($urandom % 16) == 0;
      hif.flush_exceptionM   = ($urandom % 20) == 0;
      hif.flush_pred_failedE = ($urandom % 12) == 0;
      hif.jumpD              = ($urandom % 8) == 0;
      hif.pred_takeD         = ($urandom % 8) == 0;
      for (int p = 0; p < NP; p++) hif.rd_addrD[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int s = 0; s < NS; s++) hif.wr_addr[s*AW +: AW] = AW'($urandom_range(0, 7));
      hif.wr_en         = NS'($urandom);
      hif.late          = NS'($urandom) & NS'($urandom);
      hif.lop_issueE    = ($urandom % 3) == 0;
      hif.lop_addrE     = AW'($urandom_range(0, 7));
      hif.lop_done      = ($urandom % 4) == 0;
      hif.lop_done_addr = AW'($urandom_range(0, 7));
      hif.lop_kill      = ($urandom % 40) == 0;
      rst               = ($urandom % 250) == 0;
    end
    tick(); idle(); rst = 1'b0;
    @(negedge clk);
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order pipeline. It supports a configurable number of post-decode stages and decode read ports, and selects the youngest forwarding source per read port. It stalls decode on late results: loads and mfc0 in stage, plus long-latency writebacks tracked in a register scoreboard. A small FSM holds an exception flush until a concurrent cache stall clears. It sits beside the decode stage and drives every pipeline register's stall/flush.

## Interface
- NUM_STAGES, 4, forwarding/writer stages after D (index NUM_STAGES-1 = E … 0 = W)
- NUM_RD_PORTS, 2, decode register read ports
- REG_AW, 5, register address width
- FWD_W, $clog2(NUM_STAGES+1), forward-select width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_cache_stall, d_cache_stall, alu_stallE  in  1 each  stall requests
- flush_exceptionM  in  1  exception flush pulse
- flush_pred_failedE, jumpD, pred_takeD  in  1 each  control-flow redirects
- rd_addrD  in  NUM_RD_PORTS*REG_AW  decode source registers
- wr_en  in  NUM_STAGES  per-stage register write enable
- wr_addr  in  NUM_STAGES*REG_AW  per-stage destination
- late  in  NUM_STAGES  stage result not yet available (load/mfc0)
- lop_issueE, lop_addrE  in  1, REG_AW  long-latency op leaving E
- lop_done, lop_done_addr  in  1, REG_AW  long op writeback
- lop_kill  in  1  abort all outstanding long ops
- forward_sel  out  NUM_RD_PORTS*FWD_W  0 none, k = stage k-1
- stallF, stallF2, stallD  out  1 each
- stall_bk, flush_bk  out  NUM_STAGES each  stall/flush for E..W
- flushF2, flushD  out  1 each
- stallDblank, longest_stall  out  1 each
- perf_lu_cnt, perf_mem_cnt  out  32 each  performance counters (see Configuration)

## Operation
- forward_sel per port: address ≠ 0; highest k with wr_en[k-1] & wr_addr match; else 0. Combinational.
- Load-use: any port with forward_sel=k and late[k-1].
- Scoreboard: busy[2**REG_AW] bits.
  - A port stalls if its address is busy and ≠ 0.
  - lop_issueE & ~stall_bk[E] & ~flush_bk[E] sets busy[lop_addrE].
  - lop_done clears busy[lop_done_addr].
  - Set and clear of the same address in one cycle: set wins.
  - lop_kill clears all bits and overrides set.
  - busy[0] is always 0.
- stallDblank = load-use | scoreboard stall.
- cstall = i_cache_stall | d_cache_stall | alu_stallE.
- longest_stall = cstall.
- stallD = stallF2 = cstall | stallDblank.
- stallF = stallD & ~xflush.
- stall_bk = all-ones when cstall.
- xflush = flush_exceptionM | (state==XPEND).
- flushF2 = xflush | flush_pred_failedE | ((jumpD|pred_takeD) & ~stallF2).
- flushD = xflush | (flush_pred_failedE & ~stallD).
- flush_bk[E] = xflush | (stallDblank & ~cstall).
- Other flush_bk bits = xflush, except flush_bk[0] (W), which is 0.
- FSM:
  - RUN→XPEND on flush_exceptionM & (i_cache_stall|d_cache_stall).
  - XPEND→RUN on the first cycle both cache stalls are low; flushes are still asserted that cycle.
  - A new flush_exceptionM while in XPEND keeps the state at XPEND.

## Timing
- Forwarding, stall and flush outputs are combinational, with the FSM state and busy bits as the only state.
- Scoreboard updates are visible to stall logic the cycle after the event; no bypass of lop_done in the same cycle.
- Reset: busy all 0, state RUN, counters 0. All outputs follow from that state and the inputs; with idle inputs every output is 0.
- Reset mid-XPEND returns the FSM to RUN; the pending flush is dropped.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_lu_cnt increments each cycle stallDblank & ~cstall.
  - perf_mem_cnt increments each cycle i_cache_stall|d_cache_stall.
  - Both are 32-bit and wrap at 2^32.
- Undefined: both outputs are tied 0 and no counter flops exist.

## Structure
- Package hazard_pkg: FSM state enum {RUN, XPEND}, FWD_NONE=0, and stage-index helper constants.
- One sub-module, hazard_fwd_sel: one read port's priority match, instantiated NUM_RD_PORTS times.

## Test plan
- Defaults, rd_addrD port0=5; wr_en E and W with addr 5 → forward_sel0=4 (E wins). E write removed → 1.
- late[E]=1, E writes r7, port1 reads r7 → stallDblank=1, stallD=1, flush_bk[E]=1, stall_bk=0.
- lop_issueE r9 → next cycle read r9 gives stallD=1. lop_done r9 → stall drops the following cycle. Same-cycle issue+done r9 → busy stays 1.
- flush_exceptionM while d_cache_stall held 3 cycles → flushD/flushF2 high 4 cycles in total, stallF=0 throughout, then RUN.
- lop_kill with 3 busy registers → all cleared next cycle. Read of r0 with busy forced via issue r0 → no stall.
- HAZARD_PERF_EN: 5 load-use cycles, 3 cache-stall cycles → perf_lu_cnt=5, perf_mem_cnt=3. rst → both 0.
